// File: rtl/seq_detect_param.sv
// seq_detect_param: serial bit-pattern detector with a runtime-loadable
// PAT_LEN-bit pattern, overlapping/non-overlapping detection and input
// qualification.
// Optional feature macro: SEQDET_COUNT_EN enables the saturating match
// counter; without it match_count is tied to zero and count_clr is ignored.
//
// FSM state is the history fill level:
//   fill          | meaning
//   0             | no usable history (after reset, load or non-overlap match)
//   1..PAT_LEN-2  | that many valid bits collected toward a full window
//   PAT_LEN-1     | window full; the next valid bit can complete the pattern
module seq_detect_param #(
    parameter int                 PAT_LEN   = 4,
    parameter logic [PAT_LEN-1:0] RESET_PAT = 4'b1010,
    parameter int                 CNT_W     = 8,
    parameter int                 FILL_W    = $clog2(PAT_LEN)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    input  logic               in_bit,
    input  logic               overlap,
    input  logic               load,
    input  logic [PAT_LEN-1:0] pattern,
    input  logic               count_clr,
    output logic               match,
    output logic               match_q,
    output logic [FILL_W-1:0]  fill,
    output logic [CNT_W-1:0]   match_count
);

    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_LEN - 1);

    logic [PAT_LEN-2:0] win;
    logic [PAT_LEN-1:0] pat;
    logic [PAT_LEN-1:0] cand;
    logic [FILL_W-1:0]  fill_r;
    logic [FILL_W-1:0]  fill_nxt;

    // Candidate word: stored history with the current bit appended as LSB.
    assign cand = {win, in_bit};
    assign fill = fill_r;

    // State register: history fill level.
    always_ff @(posedge clk) begin
        if (reset) begin
            fill_r <= '0;
        end else begin
            fill_r <= fill_nxt;
        end
    end

    // Next-state: load restarts collection, a non-overlapping match discards
    // all history, otherwise the fill level climbs to a full window.
    always_comb begin
        fill_nxt = fill_r;
        if (load) begin
            fill_nxt = '0;
        end else if (in_valid) begin
            if (match) begin
                fill_nxt = overlap ? FILL_MAX : '0;
            end else if (fill_r != FILL_MAX) begin
                fill_nxt = fill_r + FILL_W'(1);
            end
        end
    end

    // Mealy output: the current valid bit completes the pattern.
    always_comb begin
        match = in_valid & ~load & ~reset & (fill_r == FILL_MAX) & (cand == pat);
    end

    // History window shifts on every qualified bit; gaps leave it untouched.
    always_ff @(posedge clk) begin
        if (reset) begin
            win <= '0;
        end else if (in_valid && !load) begin
            win <= cand[PAT_LEN-2:0];
        end
    end

    // Pattern register, reloadable at runtime.
    always_ff @(posedge clk) begin
        if (reset) begin
            pat <= RESET_PAT;
        end else if (load) begin
            pat <= pattern;
        end
    end

    // Registered copy of the match flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            match_q <= 1'b0;
        end else begin
            match_q <= match;
        end
    end

`ifdef SEQDET_COUNT_EN
    logic [CNT_W-1:0] cnt_r;

    // Saturating match counter; clear wins over a coincident match.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r <= '0;
        end else if (count_clr) begin
            cnt_r <= '0;
        end else if (match && (cnt_r != {CNT_W{1'b1}})) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

    assign match_count = cnt_r;
`else
    logic unused_count_clr;

    assign unused_count_clr = count_clr;
    assign match_count      = '0;
`endif

endmodule

// File: tb/tb_seq_detect_param.sv
// Bench for seq_detect_param: a default 4-bit instance checked against a
// queue-based history model (table, hand sequences, random), and a 6-bit
// instance with a 2-bit counter checked with hand-written sequences.
module tb_seq_detect_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

`ifdef SEQDET_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    // Instance A: PAT_LEN=4, default pattern 1010, CNT_W=8
    logic       a_reset = 1'b0, a_in_valid = 1'b0, a_in_bit = 1'b0;
    logic       a_overlap = 1'b0, a_load = 1'b0, a_count_clr = 1'b0;
    logic [3:0] a_pattern = 4'd0;
    logic       a_match, a_match_q;
    logic [1:0] a_fill;
    logic [7:0] a_match_count;

    seq_detect_param dut_a (
        .clk(clk), .reset(a_reset), .in_valid(a_in_valid), .in_bit(a_in_bit),
        .overlap(a_overlap), .load(a_load), .pattern(a_pattern),
        .count_clr(a_count_clr), .match(a_match), .match_q(a_match_q),
        .fill(a_fill), .match_count(a_match_count)
    );

    // Instance B: PAT_LEN=6, CNT_W=2
    logic       b_reset = 1'b0, b_in_valid = 1'b0, b_in_bit = 1'b0;
    logic       b_overlap = 1'b0, b_load = 1'b0, b_count_clr = 1'b0;
    logic [5:0] b_pattern = 6'd0;
    logic       b_match, b_match_q;
    logic [2:0] b_fill;
    logic [1:0] b_match_count;

    seq_detect_param #(.PAT_LEN(6), .RESET_PAT(6'b110011), .CNT_W(2)) dut_b (
        .clk(clk), .reset(b_reset), .in_valid(b_in_valid), .in_bit(b_in_bit),
        .overlap(b_overlap), .load(b_load), .pattern(b_pattern),
        .count_clr(b_count_clr), .match(b_match), .match_q(b_match_q),
        .fill(b_fill), .match_count(b_match_count)
    );

    int compared   = 0;
    int mismatched = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model for A: the bits collected since the last restart point.
    bit       hist[$];
    bit [3:0] mpat = 4'b1010;
    int       mcnt = 0;
    bit       mq   = 1'b0;

    function automatic bit model_match(bit rst, bit v, bit b, bit ld);
        int val;
        if (rst || !v || ld || hist.size() < 3) return 1'b0;
        val = 0;
        for (int i = hist.size() - 3; i < hist.size(); i++) val = (val << 1) | int'(hist[i]);
        val = (val << 1) | int'(b);
        return val == int'(mpat);
    endfunction

    // One clock of A: drive, check Mealy output, clock, update model, check state.
    task automatic step_a(input bit rst, input bit v, input bit b, input bit ld,
                          input bit ov, input bit cc, input logic [3:0] p,
                          output bit m_dut);
        bit m_exp;
        a_reset = rst; a_in_valid = v; a_in_bit = b; a_load = ld;
        a_overlap = ov; a_count_clr = cc; a_pattern = p;
        #2;
        m_exp = model_match(rst, v, b, ld);
        m_dut = a_match;
        chk("a_match", a_match, m_exp);
        @(posedge clk);
        if (rst) begin
            hist.delete(); mpat = 4'b1010; mcnt = 0; mq = 1'b0;
        end else begin
            mq = m_exp;
            if (ld) begin
                mpat = p;
                hist.delete();
            end else if (v) begin
                if (m_exp && !ov) hist.delete();
                else begin
                    hist.push_back(b);
                    if (hist.size() > 3) hist.delete(0);
                end
            end
            if (CNT_EN) begin
                if (cc) mcnt = 0;
                else if (m_exp && mcnt < 255) mcnt++;
            end
        end
        #1;
        chk("a_fill", a_fill, hist.size());
        chk("a_match_q", a_match_q, mq);
        chk("a_match_count", a_match_count, mcnt);
    endtask

    task automatic step_b(input bit v, input bit b, input bit ld, input bit ov,
                          input bit cc, input logic [5:0] p, output bit m_dut);
        b_in_valid = v; b_in_bit = b; b_load = ld; b_overlap = ov;
        b_count_clr = cc; b_pattern = p;
        #2;
        m_dut = b_match;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        bit       rst, v, b, ld, ov, cc;
        bit       em;
        bit [1:0] ef;
    } vec_t;
    vec_t tbl[$];

    task automatic add(input bit rst, input bit v, input bit b, input bit ov,
                       input bit em, input bit [1:0] ef);
        vec_t r;
        r.rst = rst; r.v = v; r.b = b; r.ld = 1'b0; r.ov = ov; r.cc = 1'b0;
        r.em = em; r.ef = ef;
        tbl.push_back(r);
    endtask

    initial begin
        bit m;
        bit gb[6];
        int bi;
        bit rst, v, b, ld, ov, cc;
        logic [3:0] p;

        // Overlapping 1,0,1,0,1,0 after reset, with one idle gap
        add(1,0,0,1, 0,0);
        add(0,1,1,1, 0,1); add(0,1,0,1, 0,2); add(0,1,1,1, 0,3);
        add(0,0,1,1, 0,3);
        add(0,1,0,1, 1,3); add(0,1,1,1, 0,3); add(0,1,0,1, 1,3);
        // Non-overlapping 1,0,1,0,1,0,1,0
        add(1,0,0,0, 0,0);
        add(0,1,1,0, 0,1); add(0,1,0,0, 0,2); add(0,1,1,0, 0,3); add(0,1,0,0, 1,0);
        add(0,1,1,0, 0,1); add(0,1,0,0, 0,2); add(0,1,1,0, 0,3); add(0,1,0,0, 1,0);

        @(posedge clk);
        #1;

        // ---------------- instance B ----------------
        b_reset = 1'b1;
        step_b(0,0,0,0,0,6'd0,m);
        b_reset = 1'b0;
        chk("b_reset_fill", b_fill, 0);
        chk("b_reset_count", b_match_count, 0);
        chk("b_reset_match_q", b_match_q, 0);
        step_b(0,0,1,0,0,6'b110011,m);
        gb = '{1,1,0,0,1,1};
        for (int i = 0; i < 6; i++) begin
            step_b(1,gb[i],0,0,0,6'd0,m);
            chk("b_gap_match", m, (i == 5));
            chk("b_gap_fill", b_fill, (i == 5) ? 0 : i + 1);
            if (i < 3) begin
                for (int g = 0; g < 3; g++) begin
                    step_b(0,0,0,0,0,6'd0,m);
                    chk("b_gap_hold", b_fill, i + 1);
                end
            end
        end
        chk("b_count_one", b_match_count, CNT_EN ? 1 : 0);
        step_b(0,0,1,1,0,6'b111111,m);
        for (int k = 1; k <= 10; k++) begin
            step_b(1,1,0,1,0,6'd0,m);
            chk("b_ones_match", m, (k >= 6));
        end
        chk("b_count_sat", b_match_count, CNT_EN ? 3 : 0);
        step_b(1,1,0,1,1,6'd0,m);
        chk("b_clr_match", m, 1);
        chk("b_clr_count", b_match_count, 0);
        step_b(1,1,0,1,0,6'd0,m);
        chk("b_after_clr", b_match_count, CNT_EN ? 1 : 0);
        chk("b_match_q", b_match_q, 1);
        step_b(0,0,0,1,0,6'd0,m);

        // ---------------- instance A: table ----------------
        for (int i = 0; i < tbl.size(); i++) begin
            step_a(tbl[i].rst, tbl[i].v, tbl[i].b, 1'b0, tbl[i].ov, 1'b0, 4'd0, m);
            chk("tbl_match", m, tbl[i].em);
            chk("tbl_fill", a_fill, tbl[i].ef);
        end

        // Mid-stream load with a simultaneous valid bit, then 1111 overlapping
        step_a(1,0,0,0,1,0,4'd0,m);
        step_a(0,1,1,0,1,0,4'd0,m);
        step_a(0,1,0,0,1,0,4'd0,m);
        step_a(0,1,1,0,1,0,4'd0,m);
        step_a(0,1,1,1,1,0,4'b1111,m);
        chk("load_match", m, 0);
        chk("load_fill", a_fill, 0);
        for (int k = 1; k <= 6; k++) begin
            step_a(0,1,1,0,1,0,4'd0,m);
            chk("ones_match", m, (k >= 4));
        end

        // Reset mid-stream, then a 0: pattern back to 1010
        step_a(0,1,1,0,1,0,4'd0,m);
        step_a(0,1,0,0,1,0,4'd0,m);
        step_a(0,1,1,0,1,0,4'd0,m);
        step_a(1,1,1,0,1,0,4'd0,m);
        chk("rst_match", m, 0);
        step_a(0,1,0,0,1,0,4'd0,m);
        chk("rst_bit_match", m, 0);
        chk("rst_bit_fill", a_fill, 1);
        chk("rst_bit_match_q", a_match_q, 0);
        step_a(0,1,1,0,1,0,4'd0,m);
        step_a(0,1,0,0,1,0,4'd0,m);
        step_a(0,1,1,0,1,0,4'd0,m);
        step_a(0,1,0,0,1,0,4'd0,m);
        chk("rst_pat_match", m, 1);

        // count_clr coincident with a match
        step_a(0,1,1,0,1,0,4'd0,m);
        step_a(0,1,0,0,1,1,4'd0,m);
        chk("clr_match", m, 1);
        chk("clr_count", a_match_count, 0);

        // Randomised stream against the model
        for (int n = 0; n < 600; n++) begin
            rst = ($urandom_range(0, 99) < 2);
            ld  = ($urandom_range(0, 99) < 4);
            cc  = ($urandom_range(0, 99) < 3);
            v   = ($urandom_range(0, 99) < 75);
            b   = $urandom_range(0, 1);
            ov  = $urandom_range(0, 1);
            p   = ($urandom_range(0, 3) == 0) ? 4'b1111 : 4'($urandom_range(0, 15));
            step_a(rst, v, b, ld, ov, cc, p, m);
        end
        bi = 0;
        while (bi < 20) begin
            step_a(0,1,1,0,1,0,4'd0,m);
            bi++;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/seq_detect_param.md
# seq_detect_param

Parametrised serial bit-pattern detector: a runtime-loadable pattern of `PAT_LEN` bits, selectable overlapping/non-overlapping detection, input qualification and an optional saturating match counter. It generalises the fixed 4-bit "1010" Mealy detectors to arbitrary pattern length and content. It sits on a serial bit stream behind a deserialiser or bit-slicer and flags pattern completion in the same cycle as the final bit.

## Interface
- `PAT_LEN`, 4, pattern length in bits; legal range 2..16.
- `RESET_PAT`, 4'b1010, pattern loaded on reset; `PAT_LEN` bits wide.
- `CNT_W`, 8, match counter width; legal range 1..32.
- `FILL_W`, $clog2(PAT_LEN), width of `fill`; derived, do not override.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  `in_bit` is valid this cycle.
- `in_bit`  in  1  serial data bit.
- `overlap`  in  1  1 = overlapping detection, 0 = non-overlapping; sampled every cycle.
- `load`  in  1  load `pattern` into the pattern register.
- `pattern`  in  PAT_LEN  new pattern; bit `PAT_LEN-1` is the first bit received.
- `count_clr`  in  1  clear the match counter.
- `match`  out  1  Mealy flag: the current valid bit completes the pattern.
- `match_q`  out  1  `match` registered by one cycle.
- `fill`  out  FILL_W  count of history bits held, saturating at `PAT_LEN-1`.
- `match_count`  out  CNT_W  saturating count of matches.

## Operation
- The state is a window register `win[PAT_LEN-2:0]` of the most recent valid bits, newest in the LSB, plus the `fill` counter. `fill` is the FSM progress state, running 0..`PAT_LEN-1`.
- The pattern register `pat` holds `RESET_PAT` after reset.
- `match` = `in_valid & ~load & ~reset & (fill == PAT_LEN-1) & ({win, in_bit} == pat)`. It is purely combinational.
- On a valid bit with no load:
  - `win` shifts left and takes `in_bit`.
  - If `match`: when `overlap=1`, `fill` holds at `PAT_LEN-1`. When `overlap=0`, `fill` goes to 0, so no history bits are reused.
  - If no match: `fill` increments, saturating at `PAT_LEN-1`.
- When `in_valid=0`, `win` and `fill` hold. Gaps in the stream are transparent.
- When `load=1`: `pat <= pattern`, `fill <= 0`, and `win` is don't-care. A simultaneous `in_valid` bit is discarded and `match` is 0. `match_count` is unaffected.
- The `overlap` level on a matching cycle decides the `fill` update for that cycle. Changing `overlap` mid-stream takes effect immediately.
- On `reset`: `fill=0`, `win=0`, `pat=RESET_PAT`, `match_q=0`, `match_count=0`, and `match` is forced to 0.

## Timing
- `match` has zero latency: it is asserted in the cycle the final pattern bit is presented, for exactly one valid cycle.
- `match_q` follows one cycle after `match`.
- `match_count` reflects a match on the cycle after it.
- A new pattern is active for the first valid bit after the `load` cycle. A full `PAT_LEN` valid bits are required before the next match can occur.
- Minimum spacing between matches: 1 valid bit when overlapping (a self-overlapping pattern such as all-ones), `PAT_LEN` valid bits when non-overlapping.
- Priority, highest first: `reset`, then `load`, then `in_valid`. For the counter: `reset`, then `count_clr`, then increment.

## Configuration
- `SEQDET_COUNT_EN` defined:
  - `match_count` increments by 1 on each cycle where `match=1`, saturating at 2^CNT_W−1.
  - `count_clr` zeroes it on the next edge. If `count_clr` and `match` occur together, the result is 0.
- Not defined:
  - The counter is not synthesised.
  - `match_count` is tied to 0 and `count_clr` is ignored.

## Test plan
- Default pattern 1010, `overlap=1`, stream 1,0,1,0,1,0 → `match` on bits 4 and 6, `match_q` one cycle after each, `match_count`=2.
- Same stream with `overlap=0` → `match` on bit 4 only, and `fill` is 0 after bit 4. Stream 1,0,1,0,1,0,1,0 → matches on bits 4 and 8.
- `PAT_LEN=6`, load 110011, send 1,1,0 with `in_valid` gaps of 3 idle cycles, then 0,1,1 → one `match` on the sixth valid bit. `fill` holds through the gaps.
- Mid-stream `load` after 1,0,1 with a simultaneous `in_valid`, then load 1111 with `overlap=1` and send six 1s → the bit on the load cycle is discarded, and `match` fires on 1s #4, #5 and #6.
- `CNT_W=2`, `SEQDET_COUNT_EN` defined, 5 overlapping matches → `match_count` saturates at 3. `count_clr` together with a `match` → 0. Rebuild without the macro → `match_count` is 0 throughout.
- Assert `reset` after 1,0,1, then send 0 → no `match`, `fill`=1, `pat`=1010, `match_q`=0.
